// File: rtl/uart_resp_pkg.sv
// Shared opcodes, response codes and state types for the UART register responder.
package uart_resp_pkg;
  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK  = 8'h06;
  localparam logic [7:0] RSP_NAK  = 8'h15;
  localparam int         NUM_REGS = 16;

  typedef enum logic [2:0] {
    IDLE, GET_ADDR, GET_DATA, EXEC, SEND, WAIT_TX
  } cmd_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP
  } rx_state_t;
endpackage

// File: rtl/uart_reg_responder_if.sv
// Serial link and status signals of the UART register responder.
// slave: the responder itself; master: whoever drives rx and observes the rest.
interface uart_reg_responder_if;
  logic       rx;
  logic       tx;
  logic       busy;
  logic       cmd_done;
  logic       cmd_err;
  logic       frame_err;
  logic [7:0] reg0_out;

  modport slave  (input rx, output tx, busy, cmd_done, cmd_err, frame_err, reg0_out);
  modport master (output rx, input tx, busy, cmd_done, cmd_err, frame_err, reg0_out);
endinterface

// File: rtl/uart_resp_phy.sv
// UART physical layer: rx synchronizer, deserializer and serializer.
// 8N1 by default; defining UART_RESP_PARITY_EN switches both directions to 8E1.
module uart_resp_phy #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       tx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err,
  input  logic [7:0] tx_byte,
  input  logic       tx_load,
  output logic       tx_busy,
  output logic       tx_done
);
  import uart_resp_pkg::*;

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
`ifdef UART_RESP_PARITY_EN
  localparam int FRAME_W = 11;
`else
  localparam int FRAME_W = 10;
`endif
  localparam logic [3:0] TX_LAST = 4'(FRAME_W - 1);

  logic             rx_meta, rx_sync, rx_prev;
  rx_state_t        rx_state;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shift;
  logic             par_ok;
  logic [CNT_W-1:0] tx_cnt;
  logic [3:0]       tx_bit;
  logic [FRAME_W-2:0] tx_sh;

`ifdef UART_RESP_PARITY_EN
  logic rx_par;
  assign par_ok = ((^rx_shift) == rx_par);
`else
  assign par_ok = 1'b1;
`endif

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Receiver: validate start at mid-bit, then sample every bit period at its centre.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state  <= RX_IDLE;
      rx_cnt    <= '0;
      rx_bit    <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_sync) begin
            rx_cnt   <= '0;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) begin
`ifdef UART_RESP_PARITY_EN
              rx_state <= RX_PAR;
`else
              rx_state <= RX_STOP;
`endif
            end
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end
`ifdef UART_RESP_PARITY_EN
        RX_PAR: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_par   <= rx_sync;
            rx_state <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end
`endif
        RX_STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            if (rx_sync && par_ok) begin
              rx_valid <= 1'b1;
              rx_byte  <= rx_shift;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Transmitter: start bit goes out on load, the rest of the frame shifts out of tx_sh.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx      <= 1'b1;
      tx_busy <= 1'b0;
      tx_cnt  <= '0;
      tx_bit  <= '0;
    end else if (!tx_busy) begin
      if (tx_load) begin
        tx_busy <= 1'b1;
        tx      <= 1'b0;
        tx_cnt  <= '0;
        tx_bit  <= '0;
`ifdef UART_RESP_PARITY_EN
        tx_sh   <= {1'b1, ^tx_byte, tx_byte};
`else
        tx_sh   <= {1'b1, tx_byte};
`endif
      end
    end else if (tx_cnt == BIT_LAST) begin
      tx_cnt <= '0;
      if (tx_bit == TX_LAST) begin
        tx_busy <= 1'b0;
        tx      <= 1'b1;
      end else begin
        tx_bit <= tx_bit + 4'd1;
        tx     <= tx_sh[0];
        tx_sh  <= {1'b1, tx_sh[FRAME_W-2:1]};
      end
    end else begin
      tx_cnt <= tx_cnt + CNT_W'(1);
    end
  end

  assign tx_done = tx_busy && (tx_cnt == BIT_LAST) && (tx_bit == TX_LAST);
endmodule

// File: rtl/uart_reg_responder.sv
// Far-end UART peer: executes 'W' addr data / 'R' addr commands on a 16x8
// register file and answers ACK, NAK or the read byte.
// Optional 8E1 framing when UART_RESP_PARITY_EN is defined (handled in the phy).
module uart_reg_responder #(
  parameter int CLK_FREQ     = 1000000,
  parameter int BAUD         = 9600,
  parameter int TIMEOUT_BITS = 20
) (
  input logic clk,
  input logic rst,
  uart_reg_responder_if.slave bus
);
  import uart_resp_pkg::*;

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int TMO_CLKS     = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TMO_W        = $clog2(TMO_CLKS + 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TMO_CLKS - 1);

  logic [7:0]       rx_byte;
  logic             rx_valid, frame_err, tx_line, tx_busy, tx_done, tx_load;
  cmd_state_t       state;
  logic [7:0]       op, addr, data, rsp;
  logic             busy, cmd_done, cmd_err;
  logic [7:0]       regs [NUM_REGS];
  logic [TMO_W-1:0] tmo;

  uart_resp_phy #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_phy (
    .clk      (clk),
    .rst      (rst),
    .rx       (bus.rx),
    .tx       (tx_line),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .tx_byte  (rsp),
    .tx_load  (tx_load),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  assign tx_load = (state == SEND) && !tx_busy;

  // Command FSM with inter-byte timeout and register file.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      cmd_done <= 1'b0;
      cmd_err  <= 1'b0;
      tmo      <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      cmd_done <= 1'b0;
      cmd_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_valid) begin
            busy <= 1'b1;
            if (rx_byte == OP_WRITE || rx_byte == OP_READ) begin
              op    <= rx_byte;
              tmo   <= TMO_LOAD;
              state <= GET_ADDR;
            end else begin
              rsp     <= RSP_NAK;
              cmd_err <= 1'b1;
              state   <= SEND;
            end
          end
        end
        GET_ADDR, GET_DATA: begin
          if (rx_valid) begin
            tmo <= TMO_LOAD;
            if (state == GET_ADDR) begin
              addr  <= rx_byte;
              state <= (op == OP_WRITE) ? GET_DATA : EXEC;
            end else begin
              data  <= rx_byte;
              state <= EXEC;
            end
          end else if (tmo == '0) begin
            state   <= IDLE;
            busy    <= 1'b0;
            cmd_err <= 1'b1;
          end else begin
            tmo <= tmo - TMO_W'(1);
          end
        end
        EXEC: begin
          state <= SEND;
          if (addr >= 8'(NUM_REGS)) begin
            rsp     <= RSP_NAK;
            cmd_err <= 1'b1;
          end else if (op == OP_WRITE) begin
            regs[addr[3:0]] <= data;
            rsp             <= RSP_ACK;
          end else begin
            rsp <= regs[addr[3:0]];
          end
        end
        SEND: begin
          if (!tx_busy) state <= WAIT_TX;
        end
        WAIT_TX: begin
          if (tx_done) begin
            cmd_done <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.tx        = tx_line;
  assign bus.busy      = busy;
  assign bus.cmd_done  = cmd_done;
  assign bus.cmd_err   = cmd_err;
  assign bus.frame_err = frame_err;
  assign bus.reg0_out  = regs[0];
endmodule

// File: tb/tb_uart_reg_responder.sv
// Bench for uart_reg_responder: drives serial commands, decodes the serial
// response and checks it against a register-file model of the command protocol.
module tb_uart_reg_responder;
  localparam int CPB = 104;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_reg_responder_if bus ();

  uart_reg_responder #(.CLK_FREQ(1000000), .BAUD(9600), .TIMEOUT_BITS(20)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int         total = 0;
  int         bad = 0;
  int         act_done = 0;
  int         act_err = 0;
  int         act_ferr = 0;
  logic [7:0] m_regs [16];
  logic [7:0] got_q [$];
  logic       flush_mon = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Model of the response for a complete command.
  function automatic logic [7:0] model_resp(input logic [7:0] b0, input logic [7:0] b1);
    if (b0 != 8'h57 && b0 != 8'h52) return 8'h15;
    if (b1 >= 8'd16) return 8'h15;
    if (b0 == 8'h57) return 8'h06;
    return m_regs[b1[3:0]];
  endfunction

  // Pulse counters and per-cycle idle checks against the model.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.cmd_done) act_done++;
      if (bus.cmd_err) act_err++;
      if (bus.frame_err) act_ferr++;
      if (!bus.busy) begin
        check("idle_tx_high", 32'(bus.tx), 32'd1);
        check("reg0_mirror", 32'(bus.reg0_out), 32'(m_regs[0]));
      end
    end
  end

  // Serial decoder on tx.
  initial begin : mon
    logic [7:0] b;
    logic       stop_b;
    logic       par_b;
    forever begin
      @(negedge clk);
      if (!rst && bus.tx == 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        if (bus.tx == 1'b0) begin
          for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = bus.tx;
          end
          par_b = ^b;
`ifdef UART_RESP_PARITY_EN
          repeat (CPB) @(negedge clk);
          par_b = bus.tx;
`endif
          repeat (CPB) @(negedge clk);
          stop_b = bus.tx;
          if (!flush_mon) begin
            check("tx_stop_bit", 32'(stop_b), 32'd1);
            check("tx_parity", 32'(par_b), 32'(^b));
          end
          got_q.push_back(b);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_b);
    bus.rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_RESP_PARITY_EN
    bus.rx = ^b;
    repeat (CPB) @(negedge clk);
`endif
    bus.rx = stop_b;
    repeat (CPB) @(negedge clk);
    bus.rx = 1'b1;
  endtask

  task automatic expect_resp(input string name, input logic [7:0] exp);
    int n;
    logic [7:0] b;
    n = 0;
    while (got_q.size() == 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (got_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: no response byte, want %02h", name, exp);
    end else begin
      b = got_q.pop_front();
      check(name, 32'(b), 32'(exp));
    end
    n = 0;
    while (bus.busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    check({name, "_busy_end"}, 32'(bus.busy), 32'd0);
    @(negedge clk);
  endtask

  // Sends a command, checks the response against the model and the hand value.
  task automatic run_cmd(input string name, input int n, input logic [7:0] b0,
                         input logic [7:0] b1, input logic [7:0] b2,
                         input logic [7:0] hand, input int exp_err);
    int d0, e0;
    logic [7:0] m;
    d0 = act_done;
    e0 = act_err;
    m = (n == 1) ? 8'h15 : model_resp(b0, b1);
    check({name, "_model"}, 32'(m), 32'(hand));
    send_byte(b0, 1'b1);
    if (n > 1) send_byte(b1, 1'b1);
    if (n > 2) send_byte(b2, 1'b1);
    if (n == 3 && b0 == 8'h57 && b1 < 8'd16) m_regs[b1[3:0]] = b2;
    expect_resp(name, m);
    check({name, "_done_cnt"}, 32'(act_done - d0), 32'd1);
    check({name, "_err_cnt"}, 32'(act_err - e0), 32'(exp_err));
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int e0, f0, n;
    bus.rx = 1'b1;
    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_tx", 32'(bus.tx), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_cmd_done", 32'(bus.cmd_done), 32'd0);
    check("rst_cmd_err", 32'(bus.cmd_err), 32'd0);
    check("rst_frame_err", 32'(bus.frame_err), 32'd0);
    check("rst_reg0", 32'(bus.reg0_out), 32'd0);

    // Write then read back.
    run_cmd("wr3", 3, 8'h57, 8'h03, 8'hA5, 8'h06, 0);
    run_cmd("rd3", 2, 8'h52, 8'h03, 8'h00, 8'hA5, 0);

    // Register 0 mirror.
    run_cmd("wr0", 3, 8'h57, 8'h00, 8'h3C, 8'h06, 0);
    check("reg0_after_wr", 32'(bus.reg0_out), 32'h3C);
    run_cmd("rd0", 2, 8'h52, 8'h00, 8'h00, 8'h3C, 0);

    // Bad opcode and out-of-range address.
    run_cmd("bad_op", 1, 8'h41, 8'h00, 8'h00, 8'h15, 1);
    run_cmd("bad_addr", 2, 8'h52, 8'h20, 8'h00, 8'h15, 1);
    run_cmd("rd3_again", 2, 8'h52, 8'h03, 8'h00, 8'hA5, 0);

    // Inter-byte timeout.
    e0 = act_err;
    send_byte(8'h57, 1'b1);
    check("tmo_busy_set", 32'(bus.busy), 32'd1);
    send_byte(8'h05, 1'b1);
    repeat (20 * CPB + 10) @(negedge clk);
    check("tmo_err_cnt", 32'(act_err - e0), 32'd1);
    check("tmo_busy", 32'(bus.busy), 32'd0);
    check("tmo_no_resp", 32'(got_q.size()), 32'd0);
    run_cmd("rd5", 2, 8'h52, 8'h05, 8'h00, 8'h00, 0);

    // Bad stop bit leaves the command FSM idle.
    f0 = act_ferr;
    send_byte(8'h52, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    check("ferr_cnt", 32'(act_ferr - f0), 32'd1);
    check("ferr_busy", 32'(bus.busy), 32'd0);
    check("ferr_no_resp", 32'(got_q.size()), 32'd0);
    run_cmd("rd3_after_ferr", 2, 8'h52, 8'h03, 8'h00, 8'hA5, 0);

    // Short low glitch is not a start bit.
    f0 = act_ferr;
    bus.rx = 1'b0;
    repeat (20) @(negedge clk);
    bus.rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("glitch_ferr", 32'(act_ferr - f0), 32'd0);
    check("glitch_busy", 32'(bus.busy), 32'd0);
    check("glitch_no_resp", 32'(got_q.size()), 32'd0);

    // Reset while the response data bits are on the line.
    run_cmd("wr0_77", 3, 8'h57, 8'h00, 8'h77, 8'h06, 0);
    send_byte(8'h52, 1'b1);
    send_byte(8'h03, 1'b1);
    n = 0;
    while (bus.tx && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("mid_rsp_started", 32'(bus.tx), 32'd0);
    repeat (3 * CPB) @(negedge clk);
    flush_mon = 1'b1;
    rst = 1'b1;
    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
    @(negedge clk);
    check("midrst_tx", 32'(bus.tx), 32'd1);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_reg0", 32'(bus.reg0_out), 32'd0);
    rst = 1'b0;
    repeat (12 * CPB) @(negedge clk);
    got_q.delete();
    flush_mon = 1'b0;
    run_cmd("rd3_after_rst", 2, 8'h52, 8'h03, 8'h00, 8'h00, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_reg_responder.md
Name: uart_reg_responder

Overview:
- Far-end UART peer for uart_top: receives serial command frames on rx, executes them against a 16x8 register file and answers on tx.
- Used in the bench and on-board as the remote endpoint of the link; speaks 8N1, LSB-first, at the same CLK_FREQ/BAUD as uart_top.

Parameters:
- CLK_FREQ, 1000000, system clock frequency in Hz
- BAUD, 9600, line rate; CLKS_PER_BIT = CLK_FREQ/BAUD (104 at defaults)
- TIMEOUT_BITS, 20, inter-byte timeout in bit periods while a command is partially received

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- rx  in  1  serial input from uart_top tx
- tx  out  1  serial output to uart_top rx
- busy  out  1  high from first byte of a command until response stop bit completes
- cmd_done  out  1  one-cycle pulse when a response byte finishes transmitting
- cmd_err  out  1  one-cycle pulse when a NAK is queued or a timeout aborts a command
- frame_err  out  1  one-cycle pulse on a bad stop bit (or parity, see option)
- reg0_out  out  8  live value of register 0

Behaviour:
- Reset (sync, rst=1 at clk edge): tx=1, busy=0, cmd_done=0, cmd_err=0, frame_err=0, reg0_out=0, all registers 0, FSM IDLE, RX/TX idle. Reset mid-frame abandons it; tx returns high the next cycle.
- RX: rx passes a 2-FF synchronizer. Falling edge in idle starts the counter; at CLKS_PER_BIT/2, if rx is high, treat it as a glitch and return to idle. Otherwise sample 8 data bits every CLKS_PER_BIT, LSB first, then the stop bit.
- If the stop bit is 0: pulse frame_err, discard the byte, and leave the command FSM unchanged.
- A valid byte raises an internal rx_valid pulse for one cycle.
- TX: load 8-bit byte; start(0), 8 data LSB-first, stop(1), each CLKS_PER_BIT clocks. tx_done pulses on the last stop-bit cycle.
- Command FSM states: IDLE, GET_ADDR, GET_DATA, EXEC, SEND, WAIT_TX.
  - IDLE: on rx_valid, opcode 0x57 ('W') or 0x52 ('R') -> GET_ADDR, busy=1. Any other byte -> queue NAK 0x15, pulse cmd_err, go to SEND.
  - GET_ADDR: on rx_valid, latch addr. For 'W' -> GET_DATA; for 'R' -> EXEC.
  - GET_DATA: on rx_valid, latch data -> EXEC.
  - EXEC (1 cycle): if addr >= 16, response = NAK and pulse cmd_err. Else 'W' writes reg[addr[3:0]] = data with response 0x06 (ACK); 'R' sets response = reg[addr[3:0]].
  - SEND: load TX -> WAIT_TX.
  - WAIT_TX: on tx_done, pulse cmd_done, busy=0 -> IDLE.
- Latency: start bit of the response begins 3 clocks after the rx_valid of the final command byte.
- Timeout: in GET_ADDR/GET_DATA, a counter of TIMEOUT_BITS*CLKS_PER_BIT clocks without rx_valid -> IDLE, busy=0, pulse cmd_err, no response sent. The counter reloads on every rx_valid.
- Bytes received during SEND/WAIT_TX are dropped; no queueing.
- A write to reg 0 updates reg0_out the cycle after EXEC.
- A frame_err during GET_ADDR/GET_DATA does not reset the timeout.

Optional Feature:
- Macro UART_RESP_PARITY_EN.
- Defined: frames are 8E1. RX checks the even-parity bit after data; a mismatch pulses frame_err and discards the byte. TX appends even parity, so frames are 11 bits.
- Undefined: 8N1 only, no parity logic.

Decomposition:
- Package uart_resp_pkg: OP_WRITE=8'h57, OP_READ=8'h52, RSP_ACK=8'h06, RSP_NAK=8'h15, NUM_REGS=16, cmd_state_t enum.
- Sub-module uart_resp_phy: synchronizer, RX deserializer and TX serializer, exposing rx_byte/rx_valid/frame_err and tx_byte/tx_load/tx_busy/tx_done.
- The top holds the FSM, timeout counter and register file.

Test Plan:
- Write then read: send 0x57,0x03,0xA5 -> tx returns 0x06, cmd_done pulses once. Send 0x52,0x03 -> tx returns 0xA5.
- Reg0 mirror: send 0x57,0x00,0x3C -> reg0_out=0x3C after EXEC; a read of address 0x00 returns 0x3C.
- Bad opcode/address: send 0x41 -> tx returns 0x15, cmd_err pulses. Send 0x52,0x20 -> tx returns 0x15, registers unchanged.
- Timeout: send 0x57,0x05, then idle 20*104+10 clocks -> cmd_err pulses, busy=0, tx stays 1. Then a read of address 0x05 returns 0x00.
- Framing: frame with stop bit 0 -> frame_err pulses, no FSM change. A 20-clock low glitch on rx produces no byte.
- Reset mid-response: assert rst during the TX data bits -> tx=1 next cycle, busy=0, reg0_out=0.
